// File: rtl/wb_writeback_unit.sv
// Writeback stage: scalar register-file write port, single-row matrix write port,
// and a 4-cycle serialiser for MOPA results with upstream stall and sticky error flag.
module wb_writeback_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned MROWS  = 4,
  parameter int unsigned RCNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   wb_mem_data,
  input  logic [XLEN-1:0]   wb_alu_o,
  input  logic [4:0]        wb_rd,
  input  logic              wb_mem2reg,
  input  logic              wb_regs_write,
  input  logic [1:0]        wb_matrix_index,
  input  logic              wb_mem2matrix,
  input  logic              wb_mem_reg2matrix,
  input  logic              wb_matrix_write,
  input  logic              wb_matrix_write_mopa,
  input  logic [1:0]        wb_mem_matrix2reg,
  input  logic [XLEN-1:0]   wb_matrix_line_data,
  input  logic [XLEN-1:0]   wb_regs_data1,
  input  logic [XLEN-1:0]   wb_matrix_mul_o [MROWS],
  input  logic [31:0]       wb_inst,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              mx_we,
  output logic [1:0]        mx_idx,
  output logic [1:0]        mx_row,
  output logic [XLEN-1:0]   mx_wdata,
  output logic              stall_o,
  output logic              err_o,
  output logic [RCNT_W-1:0] retired_cnt
);

  localparam int unsigned CntW = (MROWS > 1) ? $clog2(MROWS) : 1;

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]     buf_q [MROWS];
  logic [XLEN-1:0]     buf_d [MROWS];
  logic [1:0]          idx_q, idx_d;
  logic                err_q, err_d;
  logic [RCNT_W-1:0]   retired_q, retired_d;

  logic single_req, mopa_req;

  // Source of a single-row write is fully decided by wb_mem_reg2matrix.
  logic unused_mem2matrix;
  assign unused_mem2matrix = wb_mem2matrix;

  assign single_req = wb_matrix_write & ~wb_matrix_write_mopa;
  assign mopa_req   = wb_matrix_write & wb_matrix_write_mopa;

  // Scalar path is independent of the burst state.
  assign rf_we    = wb_regs_write & (wb_rd != 5'd0);
  assign rf_waddr = wb_rd;
  always_comb begin
    if (wb_mem_matrix2reg == 2'b10) rf_wdata = wb_matrix_line_data;
    else if (wb_mem2reg)            rf_wdata = wb_mem_data;
    else                            rf_wdata = wb_alu_o;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      for (int i = 0; i < MROWS; i++) buf_q[i] <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    idx_d     = idx_q;
    err_d     = err_q;
    retired_d = (wb_inst != 32'd0) ? retired_q + RCNT_W'(1) : retired_q;
    unique case (state_q)
      StIdle: begin
        if (mopa_req) begin
          state_d = StBurst;
          cnt_d   = '0;
          buf_d   = wb_matrix_mul_o;
          idx_d   = wb_matrix_index;
        end
      end
      StBurst: begin
        // Any matrix request during a burst is dropped and flagged.
        if (single_req || mopa_req) err_d = 1'b1;
        if (cnt_q == CntW'(MROWS - 1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mx_we    = 1'b0;
    mx_idx   = wb_matrix_index;
    mx_row   = wb_inst[21:20];
    mx_wdata = wb_mem_reg2matrix ? wb_regs_data1 : wb_matrix_line_data;
    if (state_q == StBurst) begin
      mx_we    = 1'b1;
      mx_idx   = idx_q;
      mx_row   = 2'(cnt_q);
      mx_wdata = buf_q[cnt_q];
    end else begin
      mx_we = single_req;
    end
  end

  assign stall_o     = (state_q == StBurst);
  assign err_o       = err_q;
  assign retired_cnt = retired_q;

endmodule

// File: tb/tb_wb_writeback_unit.sv
// Directed self-checking bench for wb_writeback_unit; a second instance with a
// 4-bit retired counter exercises wrap-around.
module tb_wb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_data, alu_o, line_data, regs_data1, inst;
  logic [4:0]  rd;
  logic        mem2reg, regs_write, mem2matrix, reg2matrix, mwrite, mopa;
  logic [1:0]  mindex, matrix2reg;
  logic [31:0] mul [4];

  logic        rf_we, mx_we, stall_o, err_o;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, mx_wdata, retired_cnt;
  logic [1:0]  mx_idx, mx_row;

  logic        c_rf_we, c_mx_we, c_stall, c_err;
  logic [4:0]  c_rf_waddr;
  logic [31:0] c_rf_wdata, c_mx_wdata;
  logic [1:0]  c_mx_idx, c_mx_row;
  logic [3:0]  c_retired;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_writeback_unit dut (
    .clk(clk), .rst(rst), .wb_mem_data(mem_data), .wb_alu_o(alu_o), .wb_rd(rd),
    .wb_mem2reg(mem2reg), .wb_regs_write(regs_write), .wb_matrix_index(mindex),
    .wb_mem2matrix(mem2matrix), .wb_mem_reg2matrix(reg2matrix), .wb_matrix_write(mwrite),
    .wb_matrix_write_mopa(mopa), .wb_mem_matrix2reg(matrix2reg),
    .wb_matrix_line_data(line_data), .wb_regs_data1(regs_data1), .wb_matrix_mul_o(mul),
    .wb_inst(inst), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .mx_we(mx_we),
    .mx_idx(mx_idx), .mx_row(mx_row), .mx_wdata(mx_wdata), .stall_o(stall_o), .err_o(err_o),
    .retired_cnt(retired_cnt)
  );

  wb_writeback_unit #(.RCNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .wb_mem_data(mem_data), .wb_alu_o(alu_o), .wb_rd(rd),
    .wb_mem2reg(mem2reg), .wb_regs_write(regs_write), .wb_matrix_index(mindex),
    .wb_mem2matrix(mem2matrix), .wb_mem_reg2matrix(reg2matrix), .wb_matrix_write(mwrite),
    .wb_matrix_write_mopa(mopa), .wb_mem_matrix2reg(matrix2reg),
    .wb_matrix_line_data(line_data), .wb_regs_data1(regs_data1), .wb_matrix_mul_o(mul),
    .wb_inst(inst), .rf_we(c_rf_we), .rf_waddr(c_rf_waddr), .rf_wdata(c_rf_wdata),
    .mx_we(c_mx_we), .mx_idx(c_mx_idx), .mx_row(c_mx_row), .mx_wdata(c_mx_wdata),
    .stall_o(c_stall), .err_o(c_err), .retired_cnt(c_retired)
  );

  task automatic idle_inputs();
    mem_data = '0; alu_o = '0; line_data = '0; regs_data1 = '0; inst = '0; rd = '0;
    mem2reg = 0; regs_write = 0; mem2matrix = 0; reg2matrix = 0; mwrite = 0; mopa = 0;
    mindex = '0; matrix2reg = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    inst = 32'h1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    inst = '0;
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got %0h want 0", stall_o); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err got %0h want 0", err_o); end
    checks++; if (retired_cnt !== 32'd0) begin failures++; $display("FAIL reset_retired got %0h want 0", retired_cnt); end
    checks++; if (mx_we !== 1'b0) begin failures++; $display("FAIL reset_mx_we got %0h want 0", mx_we); end
  endtask

  task automatic test_scalar();
    do_reset();
    regs_write = 1; rd = 5'd5; mem2reg = 1; mem_data = 32'hDEADBEEF; alu_o = 32'h12345678;
    #1;
    checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL scalar_we got %0h want 1", rf_we); end
    checks++; if (rf_waddr !== 5'd5) begin failures++; $display("FAIL scalar_waddr got %0h want 5", rf_waddr); end
    checks++; if (rf_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL scalar_load got %0h want deadbeef", rf_wdata); end
    mem2reg = 0; #1;
    checks++; if (rf_wdata !== 32'h12345678) begin failures++; $display("FAIL scalar_alu got %0h want 12345678", rf_wdata); end
    matrix2reg = 2'b10; mem2reg = 1; line_data = 32'h0BADF00D; #1;
    checks++; if (rf_wdata !== 32'h0BADF00D) begin failures++; $display("FAIL scalar_line got %0h want badf00d", rf_wdata); end
    rd = 5'd0; #1;
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL scalar_x0 got %0h want 0", rf_we); end
    idle_inputs();
  endtask

  task automatic test_single_row();
    do_reset();
    mwrite = 1; reg2matrix = 1; regs_data1 = 32'h11223344; mindex = 2'd2; inst = 32'h0030_0000;
    line_data = 32'hCAFEF00D;
    #1;
    checks++; if (mx_we !== 1'b1) begin failures++; $display("FAIL row_we got %0h want 1", mx_we); end
    checks++; if (mx_idx !== 2'd2) begin failures++; $display("FAIL row_idx got %0h want 2", mx_idx); end
    checks++; if (mx_row !== 2'd3) begin failures++; $display("FAIL row_row got %0h want 3", mx_row); end
    checks++; if (mx_wdata !== 32'h11223344) begin failures++; $display("FAIL row_regdata got %0h want 11223344", mx_wdata); end
    reg2matrix = 0; mem2matrix = 1; #1;
    checks++; if (mx_wdata !== 32'hCAFEF00D) begin failures++; $display("FAIL row_linedata got %0h want cafef00d", mx_wdata); end
    tick();
    idle_inputs(); #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL row_no_stall got %0h want 0", stall_o); end
  endtask

  // Issues M with the given index/rows and verifies the 4 burst cycles plus the idle cycle.
  task automatic run_mopa(input logic [1:0] idx, input logic [31:0] r0, input logic [31:0] r1,
                          input logic [31:0] r2, input logic [31:0] r3);
    logic [31:0] exp [4];
    exp[0] = r0; exp[1] = r1; exp[2] = r2; exp[3] = r3;
    mwrite = 1; mopa = 1; mindex = idx;
    mul[0] = r0; mul[1] = r1; mul[2] = r2; mul[3] = r3;
    #1;
    checks++; if (mx_we !== 1'b0) begin failures++; $display("FAIL mopa_issue_we got %0h want 0", mx_we); end
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) mul[i] = 32'hFFFF0000 | i;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL mopa_stall%0d got %0h want 1", i, stall_o); end
      checks++; if (mx_we !== 1'b1) begin failures++; $display("FAIL mopa_we%0d got %0h want 1", i, mx_we); end
      checks++; if (mx_row !== 2'(i)) begin failures++; $display("FAIL mopa_row%0d got %0h want %0h", i, mx_row, i); end
      checks++; if (mx_idx !== idx) begin failures++; $display("FAIL mopa_idx%0d got %0h want %0h", i, mx_idx, idx); end
      checks++; if (mx_wdata !== exp[i]) begin failures++; $display("FAIL mopa_data%0d got %0h want %0h", i, mx_wdata, exp[i]); end
      tick();
    end
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL mopa_end_stall got %0h want 0", stall_o); end
    checks++; if (mx_we !== 1'b0) begin failures++; $display("FAIL mopa_end_we got %0h want 0", mx_we); end
  endtask

  task automatic test_mopa();
    do_reset();
    run_mopa(2'd1, 32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3);
  endtask

  task automatic test_back_to_back();
    run_mopa(2'd3, 32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404);
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL b2b_err got %0h want 0", err_o); end
  endtask

  task automatic test_conflict();
    do_reset();
    mwrite = 1; mopa = 1; mindex = 2'd0;
    mul[0] = 32'h10; mul[1] = 32'h20; mul[2] = 32'h30; mul[3] = 32'h40;
    tick();
    idle_inputs();
    tick();
    // Cycle N+2: single-row request collides with burst row 1.
    mwrite = 1; reg2matrix = 1; regs_data1 = 32'h00000BAD; mindex = 2'd3; inst = 32'h0020_0000;
    #1;
    checks++; if (mx_row !== 2'd1) begin failures++; $display("FAIL conf_row got %0h want 1", mx_row); end
    checks++; if (mx_idx !== 2'd0) begin failures++; $display("FAIL conf_idx got %0h want 0", mx_idx); end
    checks++; if (mx_wdata !== 32'h20) begin failures++; $display("FAIL conf_data got %0h want 20", mx_wdata); end
    tick();
    idle_inputs(); #1;
    checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL conf_err_set got %0h want 1", err_o); end
    checks++; if (mx_wdata !== 32'h30) begin failures++; $display("FAIL conf_row2_data got %0h want 30", mx_wdata); end
    tick(); tick(); tick(); tick();
    checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL conf_err_sticky got %0h want 1", err_o); end
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL conf_stall_end got %0h want 0", stall_o); end
    do_reset(); #1;
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL conf_err_clear got %0h want 0", err_o); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    mwrite = 1; mopa = 1; mindex = 2'd2; inst = 32'h13;
    mul[0] = 32'h1; mul[1] = 32'h2; mul[2] = 32'h3; mul[3] = 32'h4;
    tick();
    idle_inputs();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL rmb_stall got %0h want 0", stall_o); end
    checks++; if (mx_we !== 1'b0) begin failures++; $display("FAIL rmb_we got %0h want 0", mx_we); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL rmb_err got %0h want 0", err_o); end
    checks++; if (retired_cnt !== 32'd0) begin failures++; $display("FAIL rmb_retired got %0h want 0", retired_cnt); end
    tick();
    checks++; if (mx_we !== 1'b0) begin failures++; $display("FAIL rmb_we_next got %0h want 0", mx_we); end
  endtask

  task automatic test_counter();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      inst = 32'h100 + i;
      tick();
      inst = '0;
      tick();
    end
    checks++; if (c_retired !== 4'd1) begin failures++; $display("FAIL cnt_wrap got %0h want 1", c_retired); end
    checks++; if (retired_cnt !== 32'd17) begin failures++; $display("FAIL cnt_full got %0h want 11", retired_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mul[i] = '0;
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_scalar();
    test_single_row();
    test_mopa();
    test_back_to_back();
    test_conflict();
    test_reset_mid_burst();
    test_counter();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_writeback_unit.md
Name: wb_writeback_unit

Overview:
- Writeback stage, directly downstream of the MEM/WB pipeline register; consumes its wb_* outputs.
- Drives the scalar register-file write port and the single-row matrix register-file write port.
- Serialises the 4-row MOPA result over 4 cycles through that one row port, asserting a stall to upstream while it does so.
- Keeps a retired-instruction counter and a sticky protocol-error flag.

Parameters:
- XLEN, 32, data word width.
- MROWS, 4, rows per matrix (= MOPA burst length).
- RCNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- wb_mem_data  in  XLEN  load data.
- wb_alu_o  in  XLEN  ALU result.
- wb_rd  in  5  scalar destination.
- wb_mem2reg  in  1  select load data for scalar write.
- wb_regs_write  in  1  scalar write request.
- wb_matrix_index  in  2  target matrix.
- wb_mem2matrix  in  1  single-row matrix write, source wb_matrix_line_data.
- wb_mem_reg2matrix  in  1  single-row matrix write, source wb_regs_data1.
- wb_matrix_write  in  1  matrix write request.
- wb_matrix_write_mopa  in  1  with wb_matrix_write: 4-row MOPA write.
- wb_mem_matrix2reg  in  2  2'b10 selects wb_matrix_line_data for scalar write.
- wb_matrix_line_data  in  XLEN  matrix row read data.
- wb_regs_data1  in  XLEN  scalar rs1 data.
- wb_matrix_mul_o  in  MROWS x XLEN  MOPA result rows (unpacked array).
- wb_inst  in  32  instruction word; 0 = bubble.
- rf_we  out  1  scalar write enable.
- rf_waddr  out  5  scalar write address.
- rf_wdata  out  XLEN  scalar write data.
- mx_we  out  1  matrix row write enable.
- mx_idx  out  2  matrix select.
- mx_row  out  2  row select.
- mx_wdata  out  XLEN  row data.
- stall_o  out  1  busy; upstream must present bubbles.
- err_o  out  1  sticky protocol error.
- retired_cnt  out  RCNT_W  count of non-bubble instructions.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE, row counter 0, burst buffer 0, stall_o=0, err_o=0, retired_cnt=0. Registered outputs are 0; rst has priority over every other event.
- Scalar path (combinational, all states):
  - rf_we = wb_regs_write & (wb_rd != 0).
  - rf_waddr = wb_rd.
  - rf_wdata = wb_matrix_line_data if wb_mem_matrix2reg == 2'b10, else wb_mem_data if wb_mem2reg, else wb_alu_o.
  - Scalar writes proceed during a burst.
- Single-row matrix write, condition S = wb_matrix_write & ~wb_matrix_write_mopa, in IDLE:
  - Same-cycle combinational mx_we=1, mx_idx=wb_matrix_index, mx_row=wb_inst[21:20].
  - mx_wdata = wb_regs_data1 if wb_mem_reg2matrix, else wb_matrix_line_data.
- MOPA, condition M = wb_matrix_write & wb_matrix_write_mopa:
  - In IDLE at cycle N: capture wb_matrix_mul_o[0..3] and wb_matrix_index; go to BURST, counter 0; no mx_we in cycle N.
  - BURST: mx_we=1, mx_row=counter, mx_wdata=buffer[counter], mx_idx=captured index.
  - Counter increments each cycle; after row MROWS-1, return to IDLE. Rows 0..3 are written in cycles N+1..N+4.
  - stall_o is registered and equals (state==BURST): high exactly in cycles N+1..N+4.
- Conflict: S or M arriving while in BURST is dropped (burst output unchanged) and sets err_o=1. err_o clears only on rst.
- Back-to-back: M in cycle N+5 (state IDLE again) is accepted normally.
- retired_cnt: +1 at each edge where wb_inst != 0, any state; wraps 2^RCNT_W-1 -> 0.
- Reset mid-burst: state returns to IDLE next edge, remaining rows are not written, stall_o=0.

Test Plan:
- Scalar: wb_regs_write=1, wb_rd=5, wb_mem2reg=1, wb_mem_data=0xDEADBEEF -> rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF. Same with wb_rd=0 -> rf_we=0.
- Single row: wb_matrix_write=1, wb_mem_reg2matrix=1, wb_regs_data1=0x11223344, wb_matrix_index=2, wb_inst[21:20]=3 -> same cycle mx_we=1, mx_idx=2, mx_row=3, mx_wdata=0x11223344.
- MOPA: M at cycle N, index=1, mul_o={A0,B1,C2,D3} -> mx_we in N+1..N+4 with rows 0..3 and data A0,B1,C2,D3; stall_o high exactly 4 cycles.
- Conflict: S at N+2 during burst -> no extra write, burst data unchanged, err_o=1 until rst.
- Reset mid-burst: rst=1 at N+2 -> cycle N+3 stall_o=0, mx_we=0, err_o=0, retired_cnt=0.
- Counter: RCNT_W=4, 17 non-bubble insts interleaved with wb_inst=0 bubbles -> retired_cnt=1 (wrapped).
